// File: rtl/tpu_pkg.sv
// Shared TPU types: element format, default array size
// and the output-collector state encoding.
package tpu_pkg;

  localparam int SYS_DIM_DEFAULT = 2;

  typedef logic signed [15:0] fixed16_t;

  typedef enum logic [1:0] {
    COL_IDLE,
    COL_COLLECT,
    COL_DRAIN,
    COL_DONE
  } col_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; head entry is
// presented on dout_o. Push while full is accepted only with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the simultaneous push lands in.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sys_output_collector.sv
// De-skews systolic column results into row vectors and queues them
// for the unified buffer. Define COLLECTOR_RELU_EN to clamp negatives.
module sys_output_collector
  import tpu_pkg::*;
#(
  parameter int SYS_DIM    = SYS_DIM_DEFAULT,
  parameter int DATA_W     = $bits(fixed16_t),
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      col_start,
  input  logic [ROW_W-1:0]          col_rows_in,
  input  logic [15:0]               col_size_in,
  input  logic [SYS_DIM*DATA_W-1:0] sys_data_out_x,
  input  logic [SYS_DIM-1:0]        sys_valid_out_x,
  output logic [SYS_DIM*DATA_W-1:0] ub_wr_data,
  output logic [ROW_W-1:0]          ub_wr_row,
  output logic                      ub_wr_valid,
  input  logic                      ub_wr_ready,
  output logic                      col_busy,
  output logic                      col_done,
  output logic                      col_overflow,
  output logic                      col_err
);

  localparam int VW = SYS_DIM * DATA_W;
  localparam int EW = ROW_W + VW;

  col_state_e         state_q, state_d;
  logic [ROW_W-1:0]   rows_q, rows_d;
  logic [ROW_W-1:0]   pushed_q, pushed_d;
  logic [ROW_W-1:0]   popped_q, popped_d;
  logic [SYS_DIM-1:0] mask_q, mask_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic [DATA_W-1:0]  al_data [SYS_DIM];
  logic [SYS_DIM-1:0] al_valid;

  // Column c waits SYS_DIM-1-c cycles to line up with the last column.
  for (genvar c = 0; c < SYS_DIM; c++) begin : g_skew
    localparam int D = SYS_DIM - 1 - c;
    if (D == 0) begin : g_pass
      assign al_data[c]  = sys_data_out_x[c*DATA_W +: DATA_W];
      assign al_valid[c] = sys_valid_out_x[c];
    end else begin : g_dly
      logic [DATA_W-1:0] dat_q [D];
      logic [D-1:0]      vld_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < D; i++) begin
            dat_q[i] <= '0;
          end
        end else begin
          vld_q    <= D'({vld_q, sys_valid_out_x[c]});
          dat_q[0] <= sys_data_out_x[c*DATA_W +: DATA_W];
          for (int i = 1; i < D; i++) begin
            dat_q[i] <= dat_q[i-1];
          end
        end
      end
      assign al_data[c]  = dat_q[D-1];
      assign al_valid[c] = vld_q[D-1];
    end
  end

  logic [VW-1:0]      row_vec;
  logic [DATA_W-1:0]  elem;
  logic               skew_mis;
  logic [15:0]        size_eff;
  logic [SYS_DIM-1:0] en_mask;

  always_comb begin
    row_vec  = '0;
    elem     = '0;
    skew_mis = 1'b0;
    for (int c = 0; c < SYS_DIM; c++) begin
      if (mask_q[c]) begin
        elem = al_data[c];
`ifdef COLLECTOR_RELU_EN
        if (elem[DATA_W-1]) begin
          elem = '0;
        end
`endif
        row_vec[c*DATA_W +: DATA_W] = elem;
        if (al_valid[c] != al_valid[0]) begin
          skew_mis = 1'b1;
        end
      end
    end
  end

  always_comb begin
    size_eff = col_size_in;
    if (col_size_in == 16'd0 || col_size_in > 16'(SYS_DIM)) begin
      size_eff = 16'(SYS_DIM);
    end
    for (int c = 0; c < SYS_DIM; c++) begin
      en_mask[c] = (16'(c) < size_eff);
    end
  end

  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_dout;
  logic          push_req;
  logic          push_ok;
  logic          pop;

  assign ub_wr_valid = !fifo_empty;
  assign pop         = ub_wr_valid && ub_wr_ready;
  assign push_req    = (state_q == COL_COLLECT) && al_valid[0]
                       && (pushed_q != rows_q);
  assign push_ok     = push_req && (!fifo_full || pop);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ok),
    .din_i   ({pushed_q, row_vec}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ub_wr_row  = fifo_dout[EW-1 -: ROW_W];
  assign ub_wr_data = fifo_dout[VW-1:0];

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    mask_d   = mask_q;
    pushed_d = pushed_q;
    popped_d = popped_q + ROW_W'(pop);
    ovf_d    = ovf_q;
    err_d    = err_q;

    if (push_ok) begin
      pushed_d = pushed_q + 1'b1;
    end
    if (push_req && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
    if (state_q != COL_COLLECT && |sys_valid_out_x) begin
      err_d = 1'b1;
    end
    if (state_q == COL_COLLECT && skew_mis) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      COL_IDLE: begin
        if (col_start) begin
          state_d  = COL_COLLECT;
          rows_d   = col_rows_in;
          mask_d   = en_mask;
          pushed_d = '0;
          popped_d = '0;
        end
      end
      COL_COLLECT: begin
        if (pushed_q == rows_q) begin
          state_d = COL_DRAIN;
        end
      end
      COL_DRAIN: begin
        if (popped_d == rows_q) begin
          state_d = COL_DONE;
        end
      end
      COL_DONE: state_d = COL_IDLE;
      default:  state_d = COL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COL_IDLE;
      rows_q   <= '0;
      mask_q   <= '0;
      pushed_q <= '0;
      popped_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      mask_q   <= mask_d;
      pushed_q <= pushed_d;
      popped_q <= popped_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign col_busy     = (state_q == COL_COLLECT) || (state_q == COL_DRAIN);
  assign col_done     = (state_q == COL_DONE);
  assign col_overflow = ovf_q;
  assign col_err      = err_q;

endmodule
